// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the CPU pipeline.
//   pipe_state_t     - occupancy state of an inter-stage latch (EMPTY/ONE/TWO)
//   alu_op_t         - ALU operation encoding carried in the decode payload
//   decode_payload_t - decode->execute payload, packed by the decode stage
//   DECODE_BUBBLE    - decode payload loaded on reset/flush (harmless SLTU to x0)
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    alu_op_t     alu_op;
    logic        reg_we;
  } decode_payload_t;

  localparam int DECODE_W = $bits(decode_payload_t);

  // The bubble writes nothing (reg_we=0, rd=x0), so its ALU op is irrelevant
  // architecturally; SLTU is the historical NOP encoding of the decode latch.
  localparam decode_payload_t DECODE_BUBBLE = '{
    pc:     32'h0000_0000,
    rd:     5'd0,
    alu_op: ALU_SLTU,
    reg_we: 1'b0
  };

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   CLK - clock (rising edge)
//   clr - synchronous clear, wins over inc
//   inc - count this cycle
//   cnt - current count, CNT_W bits
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear, saturating increment, or hold.
  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_latch.sv
// pipeline_latch: generic valid/ready inter-stage register for the CPU pipeline.
//   CLK       - clock, all state on rising edge
//   RST       - synchronous active-high reset
//   flush     - drop all held entries this edge (priority over transfers)
//   in_valid  - upstream offers in_data
//   in_ready  - latch accepts this cycle
//   in_data   - upstream payload (WIDTH bits)
//   out_valid - out_data holds a live entry
//   out_ready - downstream accepts this cycle
//   out_data  - head payload, always the main register
//   stall_cnt - saturating count of cycles with out_valid && !out_ready
// SKID=0: one register, in_ready combinational from out_ready.
// SKID=1: main + skid entry, in_ready purely registered.
module pipeline_latch
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_r;
  pipe_state_t      state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             valid_r;
  logic             ready_r;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             stall_s;

  // With SKID=0 the ready path is combinational so a full latch can still
  // accept when the downstream drains it in the same cycle.
  assign in_ready   = (SKID != 32'sd0) ? ready_r : (!valid_r || out_ready);
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = valid_r && out_ready;
  assign stall_s    = valid_r && !out_ready;

  // Next-state and payload steering; flush overrides every transfer.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = BUBBLE;
      skid_nxt_s  = BUBBLE;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = in_data;
          end else if (in_fire_s) begin
            // Only reachable with SKID=1: SKID=0 accepts from ONE only
            // when out_ready, which always makes it a simultaneous fire.
            state_nxt_s = TWO;
            skid_nxt_s  = in_data;
          end else if (out_fire_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = ONE;
          end
        end
        TWO: begin
          // Skid entry is younger than main, so it moves up only on drain.
          if (out_fire_s) begin
            state_nxt_s = ONE;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = TWO;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = BUBBLE;
          skid_nxt_s  = BUBBLE;
        end
      endcase
    end
  end

  // State, payload and registered valid/ready flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= EMPTY;
      main_r  <= BUBBLE;
      skid_r  <= BUBBLE;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
      valid_r <= (state_nxt_s != EMPTY);
      ready_r <= (state_nxt_s != TWO);
    end
  end

  assign out_valid = valid_r;
  assign out_data  = main_r;

  // Stall statistic uses the pre-edge valid, so a flush cycle still counts.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK(CLK),
    .clr(RST),
    .inc(stall_s),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_latch.sv
// Self-checking bench for pipeline_latch: one SKID=0/CNT_W=2 instance and one
// SKID=1/CNT_W=16 instance driven by the same inputs, each compared against a
// queue-based reference (capacity 1 with pass-through ready, or capacity 2).
module tb_pipeline_latch;

  localparam logic [31:0] BUB = 32'hDEAD_0000;

  logic        CLK = 1'b0;
  logic        RST, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        r0_in_ready, r0_out_valid;
  logic [31:0] r0_out_data;
  logic [1:0]  r0_stall_cnt;
  logic        r1_in_ready, r1_out_valid;
  logic [31:0] r1_out_data;
  logic [15:0] r1_stall_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state: held entries in arrival order, last visible payload, stall count
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] shown0, shown1;
  int          cnt0, cnt1;

  always #5 CLK = ~CLK;

  pipeline_latch #(.WIDTH(32), .SKID(0), .BUBBLE(BUB), .CNT_W(2)) dut0 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(r0_in_ready), .in_data(in_data),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_data(r0_out_data),
    .stall_cnt(r0_stall_cnt)
  );

  pipeline_latch #(.WIDTH(32), .SKID(1), .BUBBLE(BUB), .CNT_W(16)) dut1 (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(r1_in_ready), .in_data(in_data),
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
    .stall_cnt(r1_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("r0_in_ready",  32'(r0_in_ready),  32'((q0.size() == 0) || out_ready));
    chk("r0_out_valid", 32'(r0_out_valid), 32'(q0.size() > 0));
    chk("r0_out_data",  r0_out_data,       (q0.size() > 0) ? q0[0] : shown0);
    chk("r0_stall_cnt", 32'(r0_stall_cnt), 32'(cnt0));
    chk("r1_in_ready",  32'(r1_in_ready),  32'(q1.size() < 2));
    chk("r1_out_valid", 32'(r1_out_valid), 32'(q1.size() > 0));
    chk("r1_out_data",  r1_out_data,       (q1.size() > 0) ? q1[0] : shown1);
    chk("r1_stall_cnt", 32'(r1_stall_cnt), 32'(cnt1));
  endtask

  // Advance both references across one rising edge using the current inputs.
  task automatic model_edge();
    bit rdy;
    if (RST) begin
      q0.delete(); q1.delete();
      shown0 = BUB; shown1 = BUB;
      cnt0 = 0; cnt1 = 0;
    end else begin
      if ((q0.size() > 0) && !out_ready && (cnt0 < 3)) cnt0++;
      if ((q1.size() > 0) && !out_ready && (cnt1 < 65535)) cnt1++;
      if (flush) begin
        q0.delete(); q1.delete();
        shown0 = BUB; shown1 = BUB;
      end else begin
        rdy = (q0.size() == 0) || out_ready;
        if ((q0.size() > 0) && out_ready) void'(q0.pop_front());
        if (in_valid && rdy) q0.push_back(in_data);
        if (q0.size() > 0) shown0 = q0[0];
        rdy = (q1.size() < 2);
        if ((q1.size() > 0) && out_ready) void'(q1.pop_front());
        if (in_valid && rdy) q1.push_back(in_data);
        if (q1.size() > 0) shown1 = q1[0];
      end
    end
  endtask

  // Drive inputs after the falling edge, check, then cross one rising edge.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    RST = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    if (chk_en) check_all();
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] sat_exp [6];
    sat_exp[0] = 32'd1; sat_exp[1] = 32'd2; sat_exp[2] = 32'd3;
    sat_exp[3] = 32'd3; sat_exp[4] = 32'd3; sat_exp[5] = 32'd3;
    shown0 = BUB; shown1 = BUB; cnt0 = 0; cnt1 = 0;
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    @(negedge CLK);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_en = 1'b1;
    chk("rst_r0_out_valid", 32'(r0_out_valid), 32'd0);
    chk("rst_r0_out_data",  r0_out_data,       32'hDEAD_0000);
    chk("rst_r0_stall_cnt", 32'(r0_stall_cnt), 32'd0);
    chk("rst_r0_in_ready",  32'(r0_in_ready),  32'd1);
    chk("rst_r1_out_valid", 32'(r1_out_valid), 32'd0);
    chk("rst_r1_out_data",  r1_out_data,       32'hDEAD_0000);
    chk("rst_r1_stall_cnt", 32'(r1_stall_cnt), 32'd0);
    chk("rst_r1_in_ready",  32'(r1_in_ready),  32'd1);

    // Streaming 1..8 back-to-back with out_ready=1
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
      chk("stream_data",  r1_out_data,      32'(i));
      chk("stream_ready", 32'(r1_in_ready), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Back-pressure: A, B accepted, C waits, then drains A, B, C in order
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    chk("bp_c_waits", 32'(r1_in_ready), 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    chk("bp_stall_cnt", 32'(r1_stall_cnt), 32'd3);
    chk("bp_head_a",    r1_out_data,       32'hA);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    chk("bp_head_b", r1_out_data, 32'hB);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    chk("bp_head_c", r1_out_data, 32'hC);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("bp_empty", 32'(r1_out_valid), 32'd0);

    // Flush while holding two entries with C offered
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h33, 1'b0);
    chk("flush_valid", 32'(r1_out_valid), 32'd0);
    chk("flush_data",  r1_out_data,       BUB);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("flush_no_leak", 32'(r1_out_valid), 32'd0);

    // Saturation on the CNT_W=2 instance
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h55, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("sat_cnt", 32'(r0_stall_cnt), sat_exp[i]);
    end

    // Simultaneous fire on the SKID=0 instance
    step(1'b0, 1'b0, 1'b1, 32'h77, 1'b1);
    chk("sim_fire_data",  r0_out_data,       32'h77);
    chk("sim_fire_valid", 32'(r0_out_valid), 32'd1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0));
    end
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_latch.md
# pipeline_latch

Generic, parametrised inter-stage register for the CPU pipeline, replacing the hand-written per-stage latches. It carries an opaque payload between stages under a valid/ready handshake. The flush/stall semantics are the same as the existing stage latches. It can optionally add a two-entry skid buffer so `in_ready` is fully registered, and it keeps a saturating back-pressure statistic for performance counters.

## Interface
- `WIDTH`, 32: payload width in bits; at least 1.
- `SKID`, 1:
  - 0 = single register with combinational ready.
  - 1 = two-entry skid buffer with registered ready.
- `BUBBLE`, `'0`: WIDTH-bit payload value loaded on reset/flush, e.g. a NOP encoding.
- `CNT_W`, 16: stall counter width; at least 1.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `flush`  in  1  discard all held entries this edge.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  latch accepts a payload this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  head payload.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Handshake events:
  - `in_fire = in_valid && in_ready`.
  - `out_fire = out_valid && out_ready`.
  - Upstream must hold `in_data` stable while `in_valid && !in_ready`.
- Reset (RST=1 at edge):
  - state EMPTY, `out_valid`=0.
  - main and skid registers = BUBBLE.
  - `stall_cnt`=0.
- Flush (`flush`=1, RST=0):
  - next state EMPTY; main and skid = BUBBLE.
  - Any `in_fire` that cycle is accepted and dropped.
  - `stall_cnt` is unaffected.
  - Flush has priority over all transfers.
- SKID=0:
  - `in_ready = !out_valid || out_ready`.
  - On `in_fire`: main ← `in_data`, `out_valid` ← 1.
  - On `out_fire` without `in_fire`: `out_valid` ← 0, main holds its value.
- SKID=1 state machine (EMPTY/ONE/TWO); `out_valid` = state≠EMPTY; `in_ready` = state≠TWO.
  - EMPTY: `in_fire` → ONE, main ← in.
  - ONE, `in_fire` && `out_fire`: stay ONE, main ← in.
  - ONE, `in_fire` only: → TWO, skid ← in.
  - ONE, `out_fire` only: → EMPTY, main holds.
  - TWO: `out_fire` → ONE, main ← skid. No accept is possible (`in_ready`=0).
- `out_data` is always the main register, in both modes.
- `stall_cnt`:
  - +1 on each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1; no wrap.
  - Counted on the pre-edge state, including a cycle where flush also asserts.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid`/`out_data`.
- Throughput: 1 transfer/cycle sustained with `out_ready`=1, in both modes.
- SKID=0: `in_ready` is combinational from `out_ready`.
- SKID=1: `in_ready` depends only on state (registered), so no ready path crosses the latch.
- After release of RST or flush: `out_valid`=0 the next cycle; first accept is possible in the same cycle.
- Ordering is strictly FIFO: the skid entry never overtakes main.
- Reset mid-transfer: both entries are lost and BUBBLE is visible on `out_data` the next cycle.

## Structure
- State type `pipe_state_t` {EMPTY, ONE, TWO} goes in `cpu_types_pkg`.
- Stage-specific BUBBLE constants go in `cpu_types_pkg` (e.g. the decode payload with ALUop = ALU_SLTU).
- One sub-module: `sat_counter` (CNT_W, inc, synchronous clear), used for `stall_cnt`.
- Payload structs are packed by the instantiating stage and passed as WIDTH bits.

## Test plan
- Reset with `BUBBLE`=32'hDEAD_0000: `out_valid`=0, `out_data`=32'hDEAD_0000, `stall_cnt`=0, and `in_ready`=1 in both modes.
- Streaming, SKID=1, `out_ready`=1: push 1..8 back-to-back → `out_data` 1..8 on consecutive cycles, `in_ready` stays 1.
- Back-pressure, SKID=1: push A, B, C with `out_ready`=0:
  - A and B are accepted; `in_ready`=0 while C waits.
  - After releasing `out_ready`, outputs are A, B, C in order.
  - `stall_cnt` equals the number of stalled cycles.
- Flush while in TWO (entries A, B, `in_valid`=1 with C): next cycle `out_valid`=0, `out_data`=BUBBLE; C and B never appear.
- Simultaneous fire, SKID=0: `out_valid`=1, `out_ready`=1, `in_valid`=1 with X → next cycle `out_data`=X, `out_valid`=1.
- Saturation, CNT_W=2: hold `out_valid`=1, `out_ready`=0 for 6 cycles → `stall_cnt` reads 1,2,3,3,3,3.
